// File: rtl/section_pkg.sv
// Shared types and elaboration helpers for the section scheduler.
package section_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSync   = 2'd1,
    StActive = 2'd2
  } sched_state_e;

  // Size of one section along an axis (pixels per section row, or lines per section column).
  function automatic int unsigned sec_dim(input int unsigned res, input int unsigned num);
    return res / num;
  endfunction

  // Counter width for a given range; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  // True when the section count evenly splits the resolution.
  function automatic bit divides(input int unsigned res, input int unsigned num);
    return (num != 0) && ((res % num) == 0);
  endfunction

endpackage

// File: rtl/report_fifo.sv
// Two-entry valid/ready FIFO for section-complete reports; flags pushes it cannot accept.
module report_fifo #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             drop_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             empty;
  logic             full;
  logic             pop_en;
  logic             push_en;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign pop_en  = !empty && pop_ready_i;
  // A pop in the same cycle frees the slot, so a full queue can still take the push.
  assign push_en = push_i && (!full || pop_en);
  assign drop_o  = push_i && !push_en;
  assign valid_o = !empty;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push_en} - {1'b0, pop_en};
    end
  end

endmodule

// File: rtl/section_scheduler.sv
// Frame/section sequencer: tracks pixel position, drives the bank index of each active pixel,
// and queues a report whenever a section of the frame grid has been fully written.
module section_scheduler
  import section_pkg::*;
#(
  parameter int unsigned X_RESOLUTION   = 640,
  parameter int unsigned Y_RESOLUTION   = 480,
  parameter int unsigned X_NUM_SECTIONS = 4,
  parameter int unsigned Y_NUM_SECTIONS = 4,
  localparam int unsigned SEC_IDX_W     = cnt_w(X_NUM_SECTIONS * Y_NUM_SECTIONS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 valid_i,
  input  logic                 ready_i,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  input  logic                 vde_i,
  output logic [SEC_IDX_W-1:0] sec_idx_o,
  output logic                 sec_en_o,
  output logic                 rpt_valid_o,
  input  logic                 rpt_ready_i,
  output logic [SEC_IDX_W-1:0] rpt_idx_o,
  output logic                 frame_done_o,
  output logic                 overflow_o,
  output logic                 sync_err_o
);

  localparam int unsigned SecW = sec_dim(X_RESOLUTION, X_NUM_SECTIONS);
  localparam int unsigned SecH = sec_dim(Y_RESOLUTION, Y_NUM_SECTIONS);
  localparam int unsigned XcW  = cnt_w(SecW);
  localparam int unsigned YcW  = cnt_w(SecH);
  localparam int unsigned XsW  = cnt_w(X_NUM_SECTIONS);
  localparam int unsigned YsW  = cnt_w(Y_NUM_SECTIONS);

  localparam logic [XcW-1:0] XCntLast = XcW'(SecW - 1);
  localparam logic [YcW-1:0] YCntLast = YcW'(SecH - 1);
  localparam logic [XsW-1:0] XSecLast = XsW'(X_NUM_SECTIONS - 1);
  localparam logic [YsW-1:0] YSecLast = YsW'(Y_NUM_SECTIONS - 1);

  if (!divides(X_RESOLUTION, X_NUM_SECTIONS)) begin : gen_x_div_chk
    $error("X_RESOLUTION must be a multiple of X_NUM_SECTIONS");
  end
  if (!divides(Y_RESOLUTION, Y_NUM_SECTIONS)) begin : gen_y_div_chk
    $error("Y_RESOLUTION must be a multiple of Y_NUM_SECTIONS");
  end

  sched_state_e   state_q, state_d;
  logic [XcW-1:0] x_cnt_q, x_cnt_d;
  logic [YcW-1:0] y_cnt_q, y_cnt_d;
  logic [XsW-1:0] x_sec_q, x_sec_d;
  logic [YsW-1:0] y_sec_q, y_sec_d;
  logic           frame_done_q, frame_done_d;
  logic           sync_err_q, sync_err_d;
  logic           overflow_q;

  logic                 beat;
  logic                 act_beat;
  logic                 sec_done;
  logic                 frame_last;
  logic                 push;
  logic                 drop;
  logic                 clr_all;
  logic                 sec_en;
  logic [SEC_IDX_W-1:0] sec_idx;

  assign beat     = valid_i && ready_i;
  assign act_beat = beat && vde_i;
  // Section finishes on its bottom-right pixel; the frame on the bottom-right section's.
  assign sec_done   = (x_cnt_q == XCntLast) && (y_cnt_q == YCntLast);
  assign frame_last = sec_done && (x_sec_q == XSecLast) && (y_sec_q == YSecLast);
  assign sec_idx    = SEC_IDX_W'(y_sec_q) * SEC_IDX_W'(X_NUM_SECTIONS) + SEC_IDX_W'(x_sec_q);

  // Next-state, position counters, report push and flag updates.
  always_comb begin
    state_d      = state_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    x_sec_d      = x_sec_q;
    y_sec_d      = y_sec_q;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err_q;
    push         = 1'b0;
    clr_all      = 1'b0;
    sec_en       = (state_q == StActive) && act_beat;

    if (!enable_i) begin
      state_d = StIdle;
      clr_all = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSync;
        end
        StSync: begin
          clr_all = 1'b1;
          if (beat && vsync_i) begin
            state_d = StActive;
          end
        end
        StActive: begin
          if (act_beat && frame_last) begin
            push         = 1'b1;
            frame_done_d = 1'b1;
            clr_all      = 1'b1;
            state_d      = StSync;
          end else if (beat && vsync_i) begin
            // Early vsync: the consumer sees a short frame; restart counting from the top.
            sync_err_d = 1'b1;
            clr_all    = 1'b1;
          end else if (beat && hsync_i) begin
            x_cnt_d = '0;
            x_sec_d = '0;
          end else if (act_beat) begin
            push = sec_done;
            if (x_cnt_q == XCntLast) begin
              x_cnt_d = '0;
              if (x_sec_q == XSecLast) begin
                x_sec_d = '0;
                if (y_cnt_q == YCntLast) begin
                  y_cnt_d = '0;
                  y_sec_d = (y_sec_q == YSecLast) ? '0 : y_sec_q + YsW'(1);
                end else begin
                  y_cnt_d = y_cnt_q + YcW'(1);
                end
              end else begin
                x_sec_d = x_sec_q + XsW'(1);
              end
            end else begin
              x_cnt_d = x_cnt_q + XcW'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          clr_all = 1'b1;
        end
      endcase
    end

    if (clr_all) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
      x_sec_d = '0;
      y_sec_d = '0;
    end
  end

  // State, counters and sticky flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      x_sec_q      <= '0;
      y_sec_q      <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      x_sec_q      <= x_sec_d;
      y_sec_q      <= y_sec_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      overflow_q   <= overflow_q | drop;
    end
  end

  report_fifo #(
    .Width (SEC_IDX_W)
  ) u_report_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (sec_idx),
    .pop_ready_i (rpt_ready_i),
    .valid_o     (rpt_valid_o),
    .data_o      (rpt_idx_o),
    .drop_o      (drop)
  );

  assign sec_idx_o    = sec_idx;
  assign sec_en_o     = sec_en;
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;
  assign sync_err_o   = sync_err_q;

endmodule

// File: tb/tb_section_scheduler.sv
// Scoreboard bench for section_scheduler on an 8x4 frame split into a 2x2 grid (4x2 sections).
module tb_section_scheduler;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic       valid_i;
  logic       ready_i;
  logic       hsync_i;
  logic       vsync_i;
  logic       vde_i;
  logic       rpt_ready_i;
  logic [1:0] sec_idx_o;
  logic       sec_en_o;
  logic       rpt_valid_o;
  logic [1:0] rpt_idx_o;
  logic       frame_done_o;
  logic       overflow_o;
  logic       sync_err_o;

  int n_checks = 0;
  int n_err    = 0;
  int fd_cnt   = 0;
  int pix_q[$];
  int rpt_q[$];

  // Expected bank index of each of the 32 active pixels of a frame, raster order.
  int frame_idx[32] = '{0, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 1, 1, 1, 1,
                        2, 2, 2, 2, 3, 3, 3, 3,  2, 2, 2, 2, 3, 3, 3, 3};

  always #5 clk = ~clk;

  section_scheduler #(
    .X_RESOLUTION   (8),
    .Y_RESOLUTION   (4),
    .X_NUM_SECTIONS (2),
    .Y_NUM_SECTIONS (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .valid_i      (valid_i),
    .ready_i      (ready_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .vde_i        (vde_i),
    .sec_idx_o    (sec_idx_o),
    .sec_en_o     (sec_en_o),
    .rpt_valid_o  (rpt_valid_o),
    .rpt_ready_i  (rpt_ready_i),
    .rpt_idx_o    (rpt_idx_o),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o),
    .sync_err_o   (sync_err_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic drv(input logic v, input logic r, input logic d, input logic h, input logic s);
    valid_i = v;
    ready_i = r;
    vde_i   = d;
    hsync_i = h;
    vsync_i = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pix(input int exp_idx, input bit rpt);
    pix_q.push_back(exp_idx);
    if (rpt) rpt_q.push_back(exp_idx);
    drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Active beat that must not produce a bank write.
  task automatic pix_off(input string name);
    valid_i = 1'b1;
    ready_i = 1'b1;
    vde_i   = 1'b1;
    hsync_i = 1'b0;
    vsync_i = 1'b0;
    #3;
    check(name, sec_en_o, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // 32 active pixels; reports 2 and 3 are expected only when the queue can drain.
  task automatic frame_body(input bit all_rpts, input bit chk_lat);
    for (int n = 0; n < 32; n++) begin
      pix(frame_idx[n], (n == 11) || (n == 15) || (all_rpts && ((n == 27) || (n == 31))));
      if (chk_lat && n == 10) check("rpt_valid before first section end", rpt_valid_o, 1'b0);
      if (chk_lat && n == 11) check("rpt_valid one cycle after beat 12", rpt_valid_o, 1'b1);
    end
  endtask

  task automatic frame(input bit all_rpts, input bit chk_lat);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    frame_body(all_rpts, chk_lat);
  endtask

  // Same frame, but each beat is preceded by a stall cycle (no valid or no ready).
  task automatic bp_frame();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 32; n++) begin
      if (n % 2 == 0) drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else            drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      pix(frame_idx[n], (n == 11) || (n == 15) || (n == 27) || (n == 31));
    end
  endtask

  task automatic end_of_frame(input string name, input int fd_req);
    idle(3);
    check({name, " frame_done pulses"}, fd_cnt, fd_req);
    check({name, " pixels left"}, pix_q.size(), 0);
    check({name, " reports left"}, rpt_q.size(), 0);
    check({name, " sec_idx cleared"}, sec_idx_o, 2'd0);
  endtask

  // Monitor: compares bank writes and report pops against the scoreboard queues.
  initial begin
    int exp;
    forever begin
      @(negedge clk);
      if (rst_i !== 1'b1) begin
        if (sec_en_o) begin
          n_checks++;
          if (pix_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected bank write: got sec_en with idx %0d, required no write",
                     sec_idx_o);
          end else begin
            exp = pix_q.pop_front();
            if (sec_idx_o !== exp[1:0]) begin
              n_err++;
              $display("FAIL sec_idx: got %0d, required %0d", sec_idx_o, exp);
            end
          end
        end
        if (rpt_valid_o && rpt_ready_i) begin
          n_checks++;
          if (rpt_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected report: got idx %0d, required none", rpt_idx_o);
          end else begin
            exp = rpt_q.pop_front();
            if (rpt_idx_o !== exp[1:0]) begin
              n_err++;
              $display("FAIL rpt_idx: got %0d, required %0d", rpt_idx_o, exp);
            end
          end
        end
        if (frame_done_o) fd_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b0;
    enable_i    = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b0;
    hsync_i     = 1'b0;
    vsync_i     = 1'b0;
    vde_i       = 1'b0;
    rpt_ready_i = 1'b1;
    #2 rst_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("reset sec_idx", sec_idx_o, 2'd0);
    check("reset sec_en", sec_en_o, 1'b0);
    check("reset rpt_valid", rpt_valid_o, 1'b0);
    check("reset rpt_idx", rpt_idx_o, 2'd0);
    check("reset frame_done", frame_done_o, 1'b0);
    check("reset overflow", overflow_o, 1'b0);
    check("reset sync_err", sync_err_o, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Disabled: beats never write a bank.
    repeat (3) pix_off("idle sec_en");

    // Full frame with free-flowing reports.
    enable_i = 1'b1;
    idle(1);
    pix_off("sync without vsync");
    frame(1'b1, 1'b1);
    end_of_frame("full", 1);
    pix_off("back in sync after frame");

    // Backpressure on the pixel stream.
    bp_frame();
    end_of_frame("backpressure", 2);

    // Report queue overflow.
    check("overflow before", overflow_o, 1'b0);
    rpt_ready_i = 1'b0;
    frame(1'b0, 1'b0);
    idle(2);
    check("overflow sticky", overflow_o, 1'b1);
    check("queue holds head", rpt_valid_o, 1'b1);
    check("queue head idx", rpt_idx_o, 2'd0);
    check("overflow frame_done pulses", fd_cnt, 3);
    rpt_ready_i = 1'b1;
    for (int i = 0; i < 10 && rpt_q.size() != 0; i++) idle(1);
    check("overflow drain", rpt_q.size(), 0);
    idle(1);
    check("queue empty after drain", rpt_valid_o, 1'b0);

    // Mid-frame vsync restarts the frame.
    check("sync_err before", sync_err_o, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) pix(frame_idx[n], 1'b0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("sync_err sticky", sync_err_o, 1'b1);
    frame_body(1'b1, 1'b0);
    end_of_frame("mid vsync", 4);

    // hsync realignment, then enable drop mid-line.
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) pix(frame_idx[n], 1'b0);
    drv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) pix(frame_idx[n], 1'b0);
    for (int n = 8; n < 11; n++) pix(frame_idx[n], 1'b0);
    enable_i = 1'b0;
    idle(1);
    pix_off("after enable drop");
    enable_i = 1'b1;
    pix_off("reenable from idle");
    pix_off("reenable sync needs vsync");
    check("sync_err still sticky", sync_err_o, 1'b1);
    frame(1'b1, 1'b0);
    end_of_frame("reenable", 5);

    // Asynchronous reset mid-cycle with state built up.
    rpt_ready_i = 1'b0;
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 13; n++) pix(frame_idx[n], n == 11);
    check("pre-reset sec_idx", sec_idx_o, 2'd1);
    check("pre-reset rpt_valid", rpt_valid_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("async reset sec_idx", sec_idx_o, 2'd0);
    check("async reset rpt_valid", rpt_valid_o, 1'b0);
    check("async reset overflow", overflow_o, 1'b0);
    check("async reset sync_err", sync_err_o, 1'b0);
    check("async reset frame_done", frame_done_o, 1'b0);
    pix_q.delete();
    rpt_q.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
